// File: rtl/wb_exc_commit.sv
// Writeback-stage exception/ERTN commit unit feeding the CSR file and the pre-IF redirect path.
// Optional performance counters (exc_cnt, ertn_cnt) are built when EXC_PERF_CNT_EN is defined.
module wb_exc_commit #(
    parameter int EXC_W = 7
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ms_valid,
    output logic             ws_allowin,
    input  logic [31:0]      ms_pc,
    input  logic [31:0]      ms_vaddr,
    input  logic [EXC_W-1:0] ms_exc,
    input  logic             ms_csr_we,
    input  logic [13:0]      ms_csr_num,
    input  logic [31:0]      ms_csr_wmask,
    input  logic [31:0]      ms_csr_wvalue,
    input  logic             has_int,
    input  logic [31:0]      ex_entry,
    input  logic [31:0]      ertn_entry,
    output logic             csr_we,
    output logic [13:0]      csr_num,
    output logic [31:0]      csr_wmask,
    output logic [31:0]      csr_wvalue,
    output logic             wb_ex,
    output logic [5:0]       wb_ecode,
    output logic [8:0]       wb_esubcode,
    output logic [31:0]      wb_pc,
    output logic [31:0]      wb_vaddr,
    output logic             ertn_flush,
    output logic             pipe_flush,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    input  logic             redir_ready
`ifdef EXC_PERF_CNT_EN
    ,
    output logic [31:0]      exc_cnt,
    output logic [31:0]      ertn_cnt
`endif
);

    localparam int EXC_INT  = 0;
    localparam int EXC_ADEF = 1;
    localparam int EXC_INE  = 2;
    localparam int EXC_SYS  = 3;
    localparam int EXC_BRK  = 4;
    localparam int EXC_ALE  = 5;
    localparam int EXC_ERTN = 6;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_ALE  = 6'h09;

    localparam logic WS_READY_GO = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               ws_valid_q, ws_valid_d;
    logic [31:0]        redir_pc_q, redir_pc_d;
    logic               load;

    logic [31:0]        pc_q;
    logic [31:0]        vaddr_q;
    logic [EXC_W-1:0]   exc_q;
    logic               csr_we_q;
    logic [13:0]        csr_num_q;
    logic [31:0]        csr_wmask_q;
    logic [31:0]        csr_wvalue_q;

    logic               exc_any;
    logic               retiring;
    logic [5:0]         ecode_c;

    assign exc_any  = |exc_q[EXC_ALE:EXC_INT];
    assign retiring = ws_valid_q && (state_q == IDLE);

    // Bit order of the cause vector is also the priority order.
    always_comb begin
        ecode_c = ECODE_INT;
        if (exc_q[EXC_INT])       ecode_c = ECODE_INT;
        else if (exc_q[EXC_ADEF]) ecode_c = ECODE_ADEF;
        else if (exc_q[EXC_INE])  ecode_c = ECODE_INE;
        else if (exc_q[EXC_SYS])  ecode_c = ECODE_SYS;
        else if (exc_q[EXC_BRK])  ecode_c = ECODE_BRK;
        else if (exc_q[EXC_ALE])  ecode_c = ECODE_ALE;
    end

    assign wb_ex       = retiring && exc_any;
    assign ertn_flush  = retiring && exc_q[EXC_ERTN] && !exc_any;
    assign wb_ecode    = wb_ex ? ecode_c : 6'd0;
    assign wb_esubcode = 9'd0;
    assign wb_pc       = wb_ex ? pc_q : 32'd0;
    assign wb_vaddr    = wb_ex ? (exc_q[EXC_ADEF] ? pc_q : vaddr_q) : 32'd0;

    assign csr_we      = retiring && csr_we_q && !wb_ex;
    assign csr_num     = csr_num_q;
    assign csr_wmask   = csr_wmask_q;
    assign csr_wvalue  = csr_wvalue_q;
    assign redir_pc    = redir_pc_q;

    // A commit flushes everything upstream, so an instruction offered that cycle is dropped.
    always_comb begin
        state_d     = state_q;
        ws_valid_d  = ws_valid_q;
        redir_pc_d  = redir_pc_q;
        load        = 1'b0;
        ws_allowin  = 1'b0;
        redir_valid = 1'b0;
        pipe_flush  = 1'b0;
        case (state_q)
            IDLE: begin
                ws_allowin = !ws_valid_q || WS_READY_GO;
                if (wb_ex || ertn_flush) begin
                    pipe_flush = 1'b1;
                    redir_pc_d = wb_ex ? ex_entry : ertn_entry;
                    ws_valid_d = 1'b0;
                    state_d    = REDIR;
                end else if (ws_allowin) begin
                    ws_valid_d = ms_valid;
                    load       = ms_valid;
                end
            end
            REDIR: begin
                redir_valid = 1'b1;
                pipe_flush  = 1'b1;
                if (redir_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            ws_valid_q   <= 1'b0;
            redir_pc_q   <= 32'd0;
            pc_q         <= 32'd0;
            vaddr_q      <= 32'd0;
            exc_q        <= '0;
            csr_we_q     <= 1'b0;
            csr_num_q    <= 14'd0;
            csr_wmask_q  <= 32'd0;
            csr_wvalue_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            ws_valid_q <= ws_valid_d;
            redir_pc_q <= redir_pc_d;
            if (load) begin
                pc_q         <= ms_pc;
                vaddr_q      <= ms_vaddr;
                exc_q        <= ms_exc | {{(EXC_W-1){1'b0}}, has_int};
                csr_we_q     <= ms_csr_we;
                csr_num_q    <= ms_csr_num;
                csr_wmask_q  <= ms_csr_wmask;
                csr_wvalue_q <= ms_csr_wvalue;
            end
        end
    end

`ifdef EXC_PERF_CNT_EN
    logic [31:0] exc_cnt_q;
    logic [31:0] ertn_cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            exc_cnt_q  <= 32'd0;
            ertn_cnt_q <= 32'd0;
        end else begin
            if (wb_ex)      exc_cnt_q  <= exc_cnt_q + 32'd1;
            if (ertn_flush) ertn_cnt_q <= ertn_cnt_q + 32'd1;
        end
    end

    assign exc_cnt  = exc_cnt_q;
    assign ertn_cnt = ertn_cnt_q;
`endif

endmodule

// File: tb/tb_wb_exc_commit.sv
// Self-checking bench for wb_exc_commit: transaction-level model compared every cycle plus directed literal checks.
module tb_wb_exc_commit;

    logic        clk;
    logic        resetn;
    logic        ms_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic [31:0] ms_vaddr;
    logic [6:0]  ms_exc;
    logic        ms_csr_we;
    logic [13:0] ms_csr_num;
    logic [31:0] ms_csr_wmask;
    logic [31:0] ms_csr_wvalue;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic        pipe_flush;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;
`ifdef EXC_PERF_CNT_EN
    logic [31:0] exc_cnt;
    logic [31:0] ertn_cnt;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    wb_exc_commit #(.EXC_W(7)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .ms_valid      (ms_valid),
        .ws_allowin    (ws_allowin),
        .ms_pc         (ms_pc),
        .ms_vaddr      (ms_vaddr),
        .ms_exc        (ms_exc),
        .ms_csr_we     (ms_csr_we),
        .ms_csr_num    (ms_csr_num),
        .ms_csr_wmask  (ms_csr_wmask),
        .ms_csr_wvalue (ms_csr_wvalue),
        .has_int       (has_int),
        .ex_entry      (ex_entry),
        .ertn_entry    (ertn_entry),
        .csr_we        (csr_we),
        .csr_num       (csr_num),
        .csr_wmask     (csr_wmask),
        .csr_wvalue    (csr_wvalue),
        .wb_ex         (wb_ex),
        .wb_ecode      (wb_ecode),
        .wb_esubcode   (wb_esubcode),
        .wb_pc         (wb_pc),
        .wb_vaddr      (wb_vaddr),
        .ertn_flush    (ertn_flush),
        .pipe_flush    (pipe_flush),
        .redir_valid   (redir_valid),
        .redir_pc      (redir_pc),
        .redir_ready   (redir_ready)
`ifdef EXC_PERF_CNT_EN
        ,
        .exc_cnt       (exc_cnt),
        .ertn_cnt      (ertn_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun = testsRun + 1;
        if (actual !== expected) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [31:0] vaddr,
                                 input logic [6:0] exc, input logic we, input logic [13:0] num,
                                 input logic [31:0] mask, input logic [31:0] value);
        ms_valid      = valid;
        ms_pc         = pc;
        ms_vaddr      = vaddr;
        ms_exc        = exc;
        ms_csr_we     = we;
        ms_csr_num    = num;
        ms_csr_wmask  = mask;
        ms_csr_wvalue = value;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 32'd0, 32'd0, 7'd0, 1'b0, 14'd0, 32'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: what instruction sits in WB, and whether a redirect is outstanding.
    logic        modelReady = 1'b0;
    logic        mValid, mBusy, mCsrWe;
    logic [31:0] mPc, mVaddr, mMask, mValue, mRedirPc, mExcCnt, mErtnCnt;
    logic [6:0]  mExc;
    logic [13:0] mNum;
    logic [5:0]  codeTable [6] = '{6'h00, 6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};

    always @(posedge clk) begin
        if (!resetn) begin
            modelReady = 1'b1;
            mValid = 1'b0; mBusy = 1'b0; mRedirPc = 32'd0;
            mExcCnt = 32'd0; mErtnCnt = 32'd0;
            mExc = 7'd0; mCsrWe = 1'b0; mPc = 32'd0; mVaddr = 32'd0;
            mNum = 14'd0; mMask = 32'd0; mValue = 32'd0;
        end else if (mBusy) begin
            if (redir_ready) mBusy = 1'b0;
        end else if (mValid && (mExc != 7'd0)) begin
            mBusy = 1'b1;
            if (mExc[5:0] != 6'd0) begin
                mRedirPc = ex_entry;
                mExcCnt  = mExcCnt + 32'd1;
            end else begin
                mRedirPc = ertn_entry;
                mErtnCnt = mErtnCnt + 32'd1;
            end
            mValid = 1'b0;
        end else begin
            mValid = ms_valid;
            if (ms_valid) begin
                mPc = ms_pc; mVaddr = ms_vaddr; mCsrWe = ms_csr_we;
                mNum = ms_csr_num; mMask = ms_csr_wmask; mValue = ms_csr_wvalue;
                mExc = ms_exc;
                if (has_int) mExc[0] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : compareBlock
        logic        expEx, expErtn, expCsrWe;
        logic [5:0]  expCode;
        logic [31:0] expVaddr;
        if (modelReady) begin
            expEx    = mValid && !mBusy && (mExc[5:0] != 6'd0);
            expErtn  = mValid && !mBusy && mExc[6] && (mExc[5:0] == 6'd0);
            expCsrWe = mValid && !mBusy && mCsrWe && !expEx;
            expCode  = 6'd0;
            if (expEx) begin
                for (int i = 5; i >= 0; i--) begin
                    if (mExc[i]) expCode = codeTable[i];
                end
            end
            expVaddr = !expEx ? 32'd0 : (mExc[1] ? mPc : mVaddr);
            checkOutput("cmp_allowin", ws_allowin, !mBusy);
            checkOutput("cmp_wb_ex", wb_ex, expEx);
            checkOutput("cmp_ertn_flush", ertn_flush, expErtn);
            checkOutput("cmp_csr_we", csr_we, expCsrWe);
            checkOutput("cmp_pipe_flush", pipe_flush, expEx || expErtn || mBusy);
            checkOutput("cmp_redir_valid", redir_valid, mBusy);
            checkOutput("cmp_ecode", wb_ecode, expCode);
            checkOutput("cmp_esubcode", wb_esubcode, 32'd0);
            checkOutput("cmp_wb_pc", wb_pc, expEx ? mPc : 32'd0);
            checkOutput("cmp_wb_vaddr", wb_vaddr, expVaddr);
            if (expCsrWe) begin
                checkOutput("cmp_csr_num", csr_num, mNum);
                checkOutput("cmp_csr_wmask", csr_wmask, mMask);
                checkOutput("cmp_csr_wvalue", csr_wvalue, mValue);
            end
            if (mBusy) checkOutput("cmp_redir_pc", redir_pc, mRedirPc);
`ifdef EXC_PERF_CNT_EN
            checkOutput("cmp_exc_cnt", exc_cnt, mExcCnt);
            checkOutput("cmp_ertn_cnt", ertn_cnt, mErtnCnt);
`endif
        end
    end

    initial begin
        int redirCycles;
        resetn = 1'b0; has_int = 1'b0; redir_ready = 1'b0;
        ex_entry = 32'd0; ertn_entry = 32'd0;
        applyIdle();
        tick(); tick();
        checkOutput("rst_allowin", ws_allowin, 1);
        checkOutput("rst_wb_ex", wb_ex, 0);
        checkOutput("rst_redir_valid", redir_valid, 0);
        checkOutput("rst_pipe_flush", pipe_flush, 0);
        checkOutput("rst_csr_we", csr_we, 0);
        checkOutput("rst_redir_pc", redir_pc, 0);
        resetn = 1'b1;

        applyStimulus(1, 32'h1c000000, 32'd0, 7'd0, 1, 14'h30, 32'hFFFFFFFF, 32'h12345678);
        tick();
        applyIdle();
        checkOutput("normal_csr_we", csr_we, 1);
        checkOutput("normal_csr_num", csr_num, 32'h30);
        checkOutput("normal_wmask", csr_wmask, 32'hFFFFFFFF);
        checkOutput("normal_wvalue", csr_wvalue, 32'h12345678);
        checkOutput("normal_wb_ex", wb_ex, 0);
        checkOutput("normal_allowin", ws_allowin, 1);
        tick();
        checkOutput("normal_drain_csr_we", csr_we, 0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h1c000020 + 32'(i * 4), 32'd0, 7'd0, 1, 14'(32'h40 + i), 32'h0000FFFF, 32'hA0 + 32'(i));
            tick();
            checkOutput("b2b_csr_num", csr_num, 32'h40 + 32'(i));
            checkOutput("b2b_csr_we", csr_we, 1);
        end
        applyIdle();

        ex_entry = 32'h1c008000;
        redir_ready = 1'b0;
        applyStimulus(1, 32'h1c000010, 32'h80000003, 7'b0100000, 1, 14'h31, 32'hFFFFFFFF, 32'hDEAD);
        tick();
        checkOutput("ale_wb_ex", wb_ex, 1);
        checkOutput("ale_ecode", wb_ecode, 32'h09);
        checkOutput("ale_vaddr", wb_vaddr, 32'h80000003);
        checkOutput("ale_pc", wb_pc, 32'h1c000010);
        checkOutput("ale_csr_we", csr_we, 0);
        checkOutput("ale_flush", pipe_flush, 1);
        applyStimulus(1, 32'h1c000014, 32'd0, 7'd0, 1, 14'h32, 32'hFFFFFFFF, 32'hBEEF);
        redirCycles = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (redir_valid) redirCycles++;
            checkOutput("ale_redir_pc", redir_pc, 32'h1c008000);
            checkOutput("ale_redir_allowin", ws_allowin, 0);
        end
        redir_ready = 1'b1;
        applyIdle();
        tick();
        checkOutput("ale_redir_cycles", redirCycles, 4);
        checkOutput("ale_back_idle", redir_valid, 0);
        checkOutput("ale_back_allowin", ws_allowin, 1);
        checkOutput("ale_dropped_csr_we", csr_we, 0);
        tick();
        checkOutput("ready_idle_redir_valid", redir_valid, 0);
        checkOutput("ready_idle_allowin", ws_allowin, 1);

        applyStimulus(1, 32'h1c000abc, 32'h55, 7'b1001010, 1, 14'h33, 32'hFFFFFFFF, 32'h1);
        tick();
        applyIdle();
        checkOutput("prio_wb_ex", wb_ex, 1);
        checkOutput("prio_ecode", wb_ecode, 32'h08);
        checkOutput("prio_esubcode", wb_esubcode, 0);
        checkOutput("prio_vaddr", wb_vaddr, 32'h1c000abc);
        checkOutput("prio_ertn_flush", ertn_flush, 0);
        tick();
        checkOutput("prio_redir_pc", redir_pc, 32'h1c008000);
        tick();

        ex_entry = 32'h1c009000;
        has_int = 1'b1;
        applyStimulus(1, 32'h1c000200, 32'd0, 7'b0001000, 0, 14'd0, 32'd0, 32'd0);
        tick();
        has_int = 1'b0;
        applyIdle();
        checkOutput("int_wb_ex", wb_ex, 1);
        checkOutput("int_ecode", wb_ecode, 32'h00);
        tick();
        checkOutput("int_redir_pc", redir_pc, 32'h1c009000);
        tick();

        ertn_entry = 32'h1c000100;
        applyStimulus(1, 32'h1c000300, 32'd0, 7'b1000000, 0, 14'd0, 32'd0, 32'd0);
        tick();
        applyIdle();
        checkOutput("ertn_flush", ertn_flush, 1);
        checkOutput("ertn_wb_ex", wb_ex, 0);
        checkOutput("ertn_pipe_flush", pipe_flush, 1);
        tick();
        checkOutput("ertn_redir_valid", redir_valid, 1);
        checkOutput("ertn_redir_pc", redir_pc, 32'h1c000100);
        tick();
        checkOutput("ertn_idle_allowin", ws_allowin, 1);
        checkOutput("ertn_idle_redir", redir_valid, 0);
`ifdef EXC_PERF_CNT_EN
        checkOutput("cnt_exc", exc_cnt, 3);
        checkOutput("cnt_ertn", ertn_cnt, 1);
`endif

        redir_ready = 1'b0;
        ex_entry = 32'h1c008000;
        applyStimulus(1, 32'h1c000400, 32'h7, 7'b0100000, 0, 14'd0, 32'd0, 32'd0);
        tick();
        applyIdle();
        tick(); tick();
        checkOutput("midredir_valid", redir_valid, 1);
        resetn = 1'b0;
        tick();
        checkOutput("rst_redir_valid2", redir_valid, 0);
        checkOutput("rst_pipe_flush2", pipe_flush, 0);
        checkOutput("rst_allowin2", ws_allowin, 1);
`ifdef EXC_PERF_CNT_EN
        checkOutput("rst_exc_cnt", exc_cnt, 0);
`endif
        resetn = 1'b1;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/wb_exc_commit.md
Name: wb_exc_commit

Overview:
- Writeback-stage exception/ERTN commit unit, sitting directly upstream of the CSR file.
- Accepts the retiring instruction from the MEM stage through a valid/ready handshake and holds it in a WB register.
- Resolves the instruction's pending exception causes by priority into one ecode/esubcode, then drives the CSR file's exception inputs: wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr and ertn_flush.
- Gates the instruction's CSR write, flushes the pipeline, and holds a redirect to pre-IF until pre-IF accepts it.

Parameters:
- EXC_W, 7: width of the exception-cause vector from MEM. Bit order: [0]INT [1]ADEF [2]INE [3]SYS [4]BRK [5]ALE [6]ERTN.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- ms_valid  in  1  MEM stage holds an instruction
- ws_allowin  out  1  WB can accept (ready)
- ms_pc  in  32  instruction PC
- ms_vaddr  in  32  data address (meaningful for ALE)
- ms_exc  in  EXC_W  cause vector
- ms_csr_we  in  1  instruction writes a CSR
- ms_csr_num  in  14  CSR number
- ms_csr_wmask  in  32  CSR write mask
- ms_csr_wvalue  in  32  CSR write value
- has_int  in  1  interrupt pending, from the CSR file
- ex_entry  in  32  exception entry address, from the CSR file
- ertn_entry  in  32  ERTN return address, from the CSR file
- csr_we  out  1  CSR write enable
- csr_num  out  14  CSR number
- csr_wmask  out  32  CSR write mask
- csr_wvalue  out  32  CSR write value
- wb_ex  out  1  exception commit pulse
- wb_ecode  out  6  exception code
- wb_esubcode  out  9  exception subcode
- wb_pc  out  32  faulting PC
- wb_vaddr  out  32  bad virtual address
- ertn_flush  out  1  ERTN commit pulse
- pipe_flush  out  1  flush all upstream stages
- redir_valid  out  1  redirect request to pre-IF
- redir_pc  out  32  redirect target
- redir_ready  in  1  pre-IF accepts the redirect

Behaviour:
- **Reset** (resetn=0 at posedge):
  - state goes to IDLE; ws_valid=0.
  - All outputs are 0, except ws_allowin=1.
- **WB register:**
  - ws_allowin = (state==IDLE) && (!ws_valid || ws_ready_go).
  - ws_ready_go is always 1.
  - The register loads on ms_valid && ws_allowin.
  - When ms_valid is low at that edge, ws_valid clears.
- **has_int sampling:** has_int is sampled at load and ORed into INT (bit 0).
- **Cause resolution** (combinational on the WB register), highest priority first:

  | Cause | ecode | esubcode |
  |---|---|---|
  | INT | 0x00 | 0 |
  | ADEF | 0x08 | 0 |
  | INE | 0x0D | 0 |
  | SYS | 0x0B | 0 |
  | BRK | 0x0C | 0 |
  | ALE | 0x09 | 0 |

  - ERTN is taken only when no exception bit is set.
  - wb_vaddr = ADEF ? pc : vaddr.
- **Outputs:**
  - wb_ex = ws_valid && any exception bit && state==IDLE. It is a one-cycle pulse.
  - ertn_flush follows the same rule for an ERTN.
  - csr_we = ws_valid && ms_csr_we_reg && !wb_ex && state==IDLE. A faulting instruction never writes CSRs.
  - wb_ecode, wb_esubcode, wb_pc and wb_vaddr are valid in the wb_ex cycle; otherwise they are 0.
- **FSM** (IDLE, REDIR):
  - **IDLE:** wb_ex or ertn_flush causes pipe_flush=1 that cycle.
    - Capture redir_pc = wb_ex ? ex_entry : ertn_entry (same-cycle value).
    - Clear ws_valid; go to REDIR.
  - **REDIR:** redir_valid=1; pipe_flush=1 every cycle; ws_allowin=0.
    - redir_ready=1 moves the FSM to IDLE the next cycle.
    - redir_valid drops the same edge.
    - redir_pc stays stable while waiting.
  - Normal instructions retire in IDLE with 1-cycle WB latency.
- **Boundary cases:**
  - Exception and ERTN bits both set: exception wins; no ertn_flush.
  - ms_valid during REDIR: not accepted (allowin=0); the upstream stage is being flushed.
  - Reset during REDIR: returns to IDLE immediately; redir_valid drops.
  - redir_ready held high in IDLE: ignored.
  - Back-to-back retiring instructions: one per cycle.

Optional Feature:
- **Macro:** EXC_PERF_CNT_EN.
- **With the macro defined:**
  - Adds output exc_cnt (32 bits). It increments on each wb_ex pulse and wraps 0xFFFFFFFF to 0.
  - Adds output ertn_cnt (32 bits), with the same increment and wrap rule on each ertn_flush pulse.
  - Both reset to 0.
- **Without the macro:** neither port nor its logic exists.

Test Plan:
- Normal retire:
  - Stimulus: pc=0x1c000000, exc=0, csr_we=1, num=0x30, wvalue=0x12345678, mask=0xFFFFFFFF.
  - Required: next cycle csr_we=1 with the same values; wb_ex=0; allowin stays 1.
- ALE:
  - Stimulus: pc=0x1c000010, exc=ALE, vaddr=0x8000_0003, ex_entry=0x1c008000, redir_ready held 0 for 3 cycles.
  - Required: wb_ex pulse with ecode=0x09, wb_vaddr=0x80000003, csr_we=0.
  - Required: redir_valid=1 with redir_pc=0x1c008000 for 4 cycles; then IDLE.
- Priority:
  - Stimulus: exc=ADEF|SYS|ERTN, pc=0x1c000abc.
  - Required: ecode=0x08, esubcode=0, wb_vaddr=0x1c000abc, ertn_flush=0.
- Interrupt:
  - Stimulus: has_int=1 at load with a SYS instruction.
  - Required: ecode=0x00.
- ERTN:
  - Stimulus: exc=ERTN, ertn_entry=0x1c000100, redir_ready=1.
  - Required: ertn_flush pulse; redir_pc=0x1c000100; back in IDLE 2 cycles after load.
- Reset mid-REDIR:
  - Stimulus: resetn=0 while in REDIR.
  - Required: next cycle redir_valid=0, pipe_flush=0, allowin=1; exc_cnt=0 when EXC_PERF_CNT_EN is defined.
